// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch_queue bus: fetch enable, imem port, redirect and dequeue handshake.
// slave = the fetch queue itself, master = the pipeline/memory side driving it.
interface fetch_queue_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32,
   parameter int CNT_W  = 3
);
   logic              start_i;
   logic [ADDR_W-1:0] imem_addr_o;
   logic [INST_W-1:0] imem_instr_i;
   logic              redirect_i;
   logic [ADDR_W-1:0] redirect_pc_i;
   logic              deq_ready_i;
   logic              deq_valid_o;
   logic [ADDR_W-1:0] deq_pc_o;
   logic [INST_W-1:0] deq_instr_o;
   logic              deq_predicted_o;
   logic [CNT_W-1:0]  count_o;

   modport slave (
      input  start_i, imem_instr_i, redirect_i, redirect_pc_i, deq_ready_i,
      output imem_addr_o, deq_valid_o, deq_pc_o, deq_instr_o, deq_predicted_o, count_o
   );

   modport master (
      output start_i, imem_instr_i, redirect_i, redirect_pc_i, deq_ready_i,
      input  imem_addr_o, deq_valid_o, deq_pc_o, deq_instr_o, deq_predicted_o, count_o
   );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC owner and DEPTH-entry show-ahead fetch queue between imem and IF/ID.
// Optional j/jal predecode redirect is enabled by defining FETCH_QUEUE_PREDECODE_EN.
module fetch_queue #(
   parameter int                DEPTH    = 4,
   parameter int                ADDR_W   = 32,
   parameter int                INST_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic         clk_i,
   input  logic         rst_i,
   fetch_queue_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0] r_pc;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [ADDR_W-1:0] r_pc_mem    [DEPTH];
   logic [INST_W-1:0] r_instr_mem [DEPTH];
   logic              r_pred_mem  [DEPTH];

   logic              w_full;
   logic              w_deq_valid;
   logic              w_pop;
   logic              w_push;
   logic [ADDR_W-1:0] w_pc_plus4;
   logic [ADDR_W-1:0] w_next_pc;
   logic              w_pred;

   assign w_full      = (r_count == CNT_W'(DEPTH));
   assign w_deq_valid = (r_count != '0) & ~bus.redirect_i;
   assign w_pop       = w_deq_valid & bus.deq_ready_i;
   assign w_push      = bus.start_i & ~bus.redirect_i & (~w_full | w_pop);
   assign w_pc_plus4  = r_pc + ADDR_W'(4);

`ifdef FETCH_QUEUE_PREDECODE_EN
   logic [27:0]       w_jtarget_lo;
   logic [ADDR_W-1:0] w_jump_pc;

   // j = 000010, jal = 000011: both share the upper five opcode bits
   assign w_pred       = (bus.imem_instr_i[31:27] == 5'b00001);
   assign w_jtarget_lo = {bus.imem_instr_i[25:0], 2'b00};

   if (ADDR_W > 28) begin : g_jump_wide
      assign w_jump_pc = {w_pc_plus4[ADDR_W-1:28], w_jtarget_lo};
   end else begin : g_jump_narrow
      assign w_jump_pc = w_jtarget_lo[ADDR_W-1:0];
   end

   assign w_next_pc = w_pred ? w_jump_pc : w_pc_plus4;
`else
   assign w_pred    = 1'b0;
   assign w_next_pc = w_pc_plus4;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_pc     <= RESET_PC;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_pc_mem[i]    <= '0;
            r_instr_mem[i] <= '0;
            r_pred_mem[i]  <= 1'b0;
         end
      end else if (bus.redirect_i) begin
         r_pc     <= {bus.redirect_pc_i[ADDR_W-1:2], 2'b00};
         r_rd_ptr <= r_wr_ptr;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= r_pc;
            r_instr_mem[r_wr_ptr] <= bus.imem_instr_i;
            r_pred_mem[r_wr_ptr]  <= w_pred;
            r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
            r_pc                  <= w_next_pc;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.imem_addr_o = r_pc;
   assign bus.deq_valid_o = w_deq_valid;
   assign bus.deq_pc_o    = r_pc_mem[r_rd_ptr];
   assign bus.deq_instr_o = r_instr_mem[r_rd_ptr];
   assign bus.count_o     = r_count;

`ifdef FETCH_QUEUE_PREDECODE_EN
   assign bus.deq_predicted_o = r_pred_mem[r_rd_ptr];
`else
   assign bus.deq_predicted_o = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue (DEPTH=4, RESET_PC=0); honours FETCH_QUEUE_PREDECODE_EN.
module tb_fetch_queue;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        pred;
   } entry_t;

   logic   clk;
   logic   rst;
   logic   j_mode;
   int     n_checks;
   int     n_errors;
   entry_t sb[$];

`ifdef FETCH_QUEUE_PREDECODE_EN
   localparam logic [31:0] EXP_JNEXT = 32'h0000_0400;
   localparam logic        EXP_JPRED = 1'b1;
`else
   localparam logic [31:0] EXP_JNEXT = 32'h0000_0044;
   localparam logic        EXP_JPRED = 1'b0;
`endif

   fetch_queue_if #(.ADDR_W(32), .INST_W(32), .CNT_W(3)) bus ();

   fetch_queue #(.DEPTH(4), .ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   // sequential imem (instr == addr), with one j instruction planted at 0x40
   assign bus.imem_instr_i = (j_mode && bus.imem_addr_o == 32'h40) ? 32'h0800_0100 : bus.imem_addr_o;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_entry(input logic [31:0] pc, input logic [31:0] instr, input logic pred);
      entry_t e;
      e.pc = pc;
      e.instr = instr;
      e.pred = pred;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (!rst && bus.deq_valid_o && bus.deq_ready_i) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_pop: got pc 0x%0h with empty scoreboard", bus.deq_pc_o);
         end else begin
            entry_t e;
            e = sb.pop_front();
            chk("sb_pc", 64'(bus.deq_pc_o), 64'(e.pc));
            chk("sb_instr", 64'(bus.deq_instr_o), 64'(e.instr));
            chk("sb_pred", 64'(bus.deq_predicted_o), 64'(e.pred));
         end
      end
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      j_mode = 1'b0;
      bus.start_i = 1'b0;
      bus.redirect_i = 1'b0;
      bus.redirect_pc_i = '0;
      bus.deq_ready_i = 1'b0;

      next_cycle();
      chk("rst_count", 64'(bus.count_o), 64'd0);
      chk("rst_valid", 64'(bus.deq_valid_o), 64'd0);
      chk("rst_addr", 64'(bus.imem_addr_o), 64'h0);
      chk("rst_deq_pc", 64'(bus.deq_pc_o), 64'h0);
      chk("rst_deq_instr", 64'(bus.deq_instr_o), 64'h0);
      chk("rst_pred", 64'(bus.deq_predicted_o), 64'd0);

      // fill: no consumer, queue saturates at 4
      rst = 1'b0;
      bus.start_i = 1'b1;
      repeat (4) next_cycle();
      chk("fill_count", 64'(bus.count_o), 64'd4);
      chk("fill_deq_pc", 64'(bus.deq_pc_o), 64'h0);
      chk("fill_addr", 64'(bus.imem_addr_o), 64'h10);
      chk("fill_valid", 64'(bus.deq_valid_o), 64'd1);
      next_cycle();
      chk("full_hold_count", 64'(bus.count_o), 64'd4);
      chk("full_hold_addr", 64'(bus.imem_addr_o), 64'h10);

      // full streaming: push and pop every cycle
      for (int i = 0; i < 8; i++) expect_entry(32'(4 * i), 32'(4 * i), 1'b0);
      bus.deq_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("stream_count", 64'(bus.count_o), 64'd4);
         chk("stream_deq_pc", 64'(bus.deq_pc_o), 64'(4 * i));
         next_cycle();
      end
      bus.deq_ready_i = 1'b0;
      #1;
      chk("stream_end_head", 64'(bus.deq_pc_o), 64'h20);
      chk("stream_end_addr", 64'(bus.imem_addr_o), 64'h30);

      // redirect with misaligned target flushes the full queue
      next_cycle();
      bus.redirect_i = 1'b1;
      bus.redirect_pc_i = 32'h103;
      #1;
      chk("redir_valid_mask", 64'(bus.deq_valid_o), 64'd0);
      chk("redir_count_before", 64'(bus.count_o), 64'd4);
      next_cycle();
      bus.redirect_i = 1'b0;
      #1;
      chk("redir_count", 64'(bus.count_o), 64'd0);
      chk("redir_addr", 64'(bus.imem_addr_o), 64'h100);
      chk("redir_valid", 64'(bus.deq_valid_o), 64'd0);
      next_cycle();
      chk("redir_head_pc", 64'(bus.deq_pc_o), 64'h100);
      chk("redir_head_count", 64'(bus.count_o), 64'd1);
      chk("redir_head_valid", 64'(bus.deq_valid_o), 64'd1);
      next_cycle();
      next_cycle();

      // start low: drain three entries, PC holds
      bus.start_i = 1'b0;
      #1;
      chk("drain_count0", 64'(bus.count_o), 64'd3);
      chk("drain_addr0", 64'(bus.imem_addr_o), 64'h10C);
      expect_entry(32'h100, 32'h100, 1'b0);
      expect_entry(32'h104, 32'h104, 1'b0);
      expect_entry(32'h108, 32'h108, 1'b0);
      bus.deq_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("drain_count", 64'(bus.count_o), 64'(3 - i));
         next_cycle();
      end
      chk("drained_count", 64'(bus.count_o), 64'd0);
      chk("drained_valid", 64'(bus.deq_valid_o), 64'd0);
      chk("drained_addr", 64'(bus.imem_addr_o), 64'h10C);

      // PC wrap from all-ones
      bus.redirect_i = 1'b1;
      bus.redirect_pc_i = 32'hFFFF_FFFF;
      bus.start_i = 1'b1;
      bus.deq_ready_i = 1'b0;
      next_cycle();
      bus.redirect_i = 1'b0;
      #1;
      chk("wrap_addr0", 64'(bus.imem_addr_o), 64'hFFFF_FFFC);
      next_cycle();
      chk("wrap_addr1", 64'(bus.imem_addr_o), 64'h0);
      chk("wrap_count", 64'(bus.count_o), 64'd1);
      chk("wrap_head", 64'(bus.deq_pc_o), 64'hFFFF_FFFC);

      // predecode: j at 0x40
      j_mode = 1'b1;
      bus.redirect_i = 1'b1;
      bus.redirect_pc_i = 32'h40;
      #1;
      chk("pd_redir_valid", 64'(bus.deq_valid_o), 64'd0);
      next_cycle();
      bus.redirect_i = 1'b0;
      #1;
      chk("pd_addr", 64'(bus.imem_addr_o), 64'h40);
      chk("pd_count", 64'(bus.count_o), 64'd0);
      next_cycle();
      expect_entry(32'h40, 32'h0800_0100, EXP_JPRED);
      bus.deq_ready_i = 1'b1;
      #1;
      chk("pd_next_addr", 64'(bus.imem_addr_o), 64'(EXP_JNEXT));
      chk("pd_head_pc", 64'(bus.deq_pc_o), 64'h40);
      chk("pd_head_pred", 64'(bus.deq_predicted_o), 64'(EXP_JPRED));
      next_cycle();
      bus.deq_ready_i = 1'b0;
      bus.start_i = 1'b0;
      #1;
      chk("pd_after_count", 64'(bus.count_o), 64'd1);
      chk("pd_after_head", 64'(bus.deq_pc_o), 64'(EXP_JNEXT));
      chk("pd_after_pred", 64'(bus.deq_predicted_o), 64'd0);

      // asynchronous reset between edges
      #2;
      rst = 1'b1;
      #1;
      chk("arst_count", 64'(bus.count_o), 64'd0);
      chk("arst_valid", 64'(bus.deq_valid_o), 64'd0);
      chk("arst_addr", 64'(bus.imem_addr_o), 64'h0);
      chk("arst_deq_pc", 64'(bus.deq_pc_o), 64'h0);
      next_cycle();
      rst = 1'b0;
      next_cycle();
      chk("sb_leftover", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
